// File: rtl/sti_pkg.sv
// Shared constants for the serial-to-parallel capture stage: length codes, FSM
// encoding, FIFO entry width and the length decode used at push time.
package sti_pkg;

  localparam logic [1:0] LEN8  = 2'd0;
  localparam logic [1:0] LEN16 = 2'd1;
  localparam logic [1:0] LEN24 = 2'd2;
  localparam logic [1:0] LEN32 = 2'd3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  localparam int unsigned ENTRY_W = 35;
  localparam int unsigned CNT_W   = 6;

  // Returns {err, len}; any burst length other than 8/16/24/32 is an error.
  function automatic logic [2:0] len_decode(input logic [CNT_W-1:0] cnt);
    logic [2:0] res;
    case (cnt)
      6'd8:    res = {1'b0, LEN8};
      6'd16:   res = {1'b0, LEN16};
      6'd24:   res = {1'b0, LEN24};
      6'd32:   res = {1'b0, LEN32};
      default: res = {1'b1, LEN8};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sti_if.sv
// Ready/valid word interface between the deserializer and its consumer.
interface sti_if #(
  parameter int unsigned MAX_BITS = 32
);
  logic [MAX_BITS-1:0] word_data;
  logic [1:0]          word_len;
  logic                word_err;
  logic                word_valid;
  logic                word_ready;

  modport master (
    output word_data, word_len, word_err, word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data, word_len, word_err, word_valid,
    output word_ready
  );
endinterface

// File: rtl/sti_word_fifo.sv
// Synchronous FIFO; head reads zero when empty. A push while full is accepted
// only if a pop happens on the same edge.
module sti_word_fifo
  import sti_pkg::*;
#(
  parameter int unsigned Width = ENTRY_W,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(Depth));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_data;
  end

endmodule

// File: rtl/sti_deserializer.sv
// Captures so_valid bursts into right-justified words, infers their length and
// queues them for a ready/valid consumer.
module sti_deserializer
  import sti_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_BITS   = 32
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     so_data,
  input  logic     so_valid,
  input  logic     cfg_msb,
  sti_if.master    word,
  output logic     overflow,
  output logic     busy
);
  localparam int unsigned IDX_W = $clog2(MAX_BITS);
  localparam int unsigned EW    = MAX_BITS + 3;

  logic [0:0]          state_q;
  logic                msb_q;
  logic [CNT_W-1:0]    count_q;
  logic [MAX_BITS-1:0] sh_q;
  logic                push, fifo_full, fifo_empty;
  logic [2:0]          dec;
  logic [EW-1:0]       fifo_out;

  assign push = (state_q == RECV) && !so_valid;
  assign busy = (state_q == RECV);
  assign dec  = len_decode(count_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      msb_q   <= 1'b0;
      count_q <= '0;
      sh_q    <= '0;
    end else if (state_q == IDLE) begin
      if (so_valid) begin
        state_q <= RECV;
        msb_q   <= cfg_msb;
        count_q <= CNT_W'(1);
        // First bit lands in bit 0 for either order; the rest of sh clears.
        sh_q    <= {{(MAX_BITS-1){1'b0}}, so_data};
      end
    end else if (so_valid) begin
      // Bits past MAX_BITS are dropped so sh keeps the first MAX_BITS bits.
      if (count_q < CNT_W'(MAX_BITS)) begin
        if (msb_q) sh_q <= {sh_q[MAX_BITS-2:0], so_data};
        else       sh_q[count_q[IDX_W-1:0]] <= so_data;
      end
      if (count_q != CNT_W'(MAX_BITS + 1)) count_q <= count_q + 1'b1;
    end else begin
      state_q <= IDLE;
      count_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !word.word_ready) begin
      overflow <= 1'b1;
    end
  end

  sti_word_fifo #(
    .Width (EW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({dec, sh_q}),
    .pop       (word.word_ready),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign word.word_valid = ~fifo_empty;
  assign word.word_err   = fifo_out[EW-1];
  assign word.word_len   = fifo_out[EW-2:EW-3];
  assign word.word_data  = fifo_out[MAX_BITS-1:0];

endmodule

// File: tb/tb_sti_deserializer.sv
// Scoreboard bench: expected words are queued as bursts are driven and compared
// whenever the consumer accepts a word.
module tb_sti_deserializer;

  typedef struct packed {
    logic        err;
    logic [1:0]  len;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset, so_data, so_valid, cfg_msb, overflow, busy;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  sti_if #(.MAX_BITS(32)) wif ();

  sti_deserializer #(
    .FIFO_DEPTH (4),
    .MAX_BITS   (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .so_data  (so_data),
    .so_valid (so_valid),
    .cfg_msb  (cfg_msb),
    .word     (wif),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int n, input logic [39:0] val, input logic msb);
    logic [39:0] v;
    exp_t e;
    if (n > 32) v = msb ? (val >> (n - 32)) : val;
    else        v = val & ((40'd1 << n) - 40'd1);
    e.data = v[31:0];
    if (n == 8 || n == 16 || n == 24 || n == 32) begin
      e.err = 1'b0;
      e.len = 2'(n / 8 - 1);
    end else begin
      e.err = 1'b1;
      e.len = 2'd0;
    end
    return e;
  endfunction

  // Consumer side: every accepted word must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && wif.word_valid && wif.word_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", 64'(wif.word_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("word_data", 64'(wif.word_data), 64'(sb[0].data));
        check("word_len",  64'(wif.word_len),  64'(sb[0].len));
        check("word_err",  64'(wif.word_err),  64'(sb[0].err));
        void'(sb.pop_front());
      end
    end
  end

  task automatic idle(input int k);
    so_valid = 1'b0;
    so_data  = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_burst(input int n, input logic [39:0] val, input logic msb,
                            input bit toggle, input bit hold, input bit push);
    if (push) sb.push_back(model(n, val, msb));
    for (int i = 0; i < n; i++) begin
      so_valid = 1'b1;
      so_data  = msb ? val[n-1-i] : val[i];
      cfg_msb  = (toggle && i[0]) ? ~msb : msb;
      @(posedge clk);
      #1;
    end
    if (!hold) begin
      so_valid = 1'b0;
      so_data  = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; so_data = 1'b0; so_valid = 1'b0; cfg_msb = 1'b0;
    wif.word_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",    64'(wif.word_valid), 64'd0);
    check("rst_data",     64'(wif.word_data),  64'd0);
    check("rst_overflow", 64'(overflow),       64'd0);
    check("rst_busy",     64'(busy),           64'd0);
    reset = 1'b0;
    idle(1);

    // MSB-first 0xA5 with latency check
    send_burst(8, 40'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    check("lat_busy_last", 64'(busy), 64'd1);
    check("lat_valid_pre", 64'(wif.word_valid), 64'd0);
    idle(1);
    check("lat_valid_post", 64'(wif.word_valid), 64'd1);
    check("lat_busy_gap", 64'(busy), 64'd0);
    wait_drain("drain_a5");

    // LSB-first 0x1234, cfg_msb toggling mid-burst
    send_burst(16, 40'h1234, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1);
    wait_drain("drain_lsb");

    // Back-to-back 32-bit words with a single idle cycle
    send_burst(32, 40'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1);
    check("b2b_busy_a", 64'(busy), 64'd1);
    idle(1);
    check("b2b_busy_gap", 64'(busy), 64'd0);
    send_burst(32, 40'h0F0F0F0F, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    wait_drain("drain_b2b");

    // Illegal lengths, including a single-bit burst and a 40-bit LSB burst
    send_burst(12, 40'hABC, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    send_burst(40, 40'h12_3456_789A, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    send_burst(40, 40'hC3_8765_4321, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    send_burst(1, 40'h1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    wait_drain("drain_err");

    // Fill with consumer stalled; the fifth word is dropped
    wif.word_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_burst(8, 40'(8'h10 + i), 1'b1, 1'b0, 1'b0, i < 4);
      idle(1);
      if (i == 3) check("ovf_before", 64'(overflow), 64'd0);
    end
    check("ovf_set", 64'(overflow), 64'd1);
    check("hold_valid", 64'(wif.word_valid), 64'd1);
    check("hold_data", 64'(wif.word_data), 64'(sb[0].data));
    idle(2);
    check("hold_data2", 64'(wif.word_data), 64'(sb[0].data));
    wif.word_ready = 1'b1;
    wait_drain("drain_full");

    // Push coinciding with a pop while full must not drop
    wif.word_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_burst(8, 40'(8'h20 + i), 1'b1, 1'b0, 1'b0, 1'b1);
      idle(1);
    end
    send_burst(8, 40'h30, 1'b1, 1'b0, 1'b0, 1'b1);
    wif.word_ready = 1'b1;
    idle(1);
    check("ovf_sticky", 64'(overflow), 64'd1);
    wait_drain("drain_pushpop");

    // Reset in the middle of a burst, with a word still queued
    wif.word_ready = 1'b0;
    send_burst(8, 40'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    send_burst(5, 40'h1B, 1'b1, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    sb.delete();
    check("mid_rst_valid",    64'(wif.word_valid), 64'd0);
    check("mid_rst_data",     64'(wif.word_data),  64'd0);
    check("mid_rst_len",      64'(wif.word_len),   64'd0);
    check("mid_rst_err",      64'(wif.word_err),   64'd0);
    check("mid_rst_overflow", 64'(overflow),       64'd0);
    check("mid_rst_busy",     64'(busy),           64'd0);
    reset = 1'b0;
    idle(2);
    check("post_rst_valid", 64'(wif.word_valid), 64'd0);
    wif.word_ready = 1'b1;
    send_burst(8, 40'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    wait_drain("drain_3c");
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sti_deserializer.md
Name: sti_deserializer

Overview:
- Downstream capture stage for the serial transmitter's so_data/so_valid stream.
- Reassembles each so_valid burst into a right-justified parallel word and infers its length (8/16/24/32 bits) from the burst length.
- Queues each word in a small FIFO and presents it on a ready/valid interface for checking or loopback.
- Bit order (MSB-first or LSB-first) is a configuration input sampled per burst.

Parameters:
FIFO_DEPTH, 4, number of queued words; power of two, minimum 2.
MAX_BITS, 32, widest legal word; fixes word_data width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
so_data  in  1  serial bit, sampled when so_valid=1
so_valid  in  1  burst qualifier; a burst is a maximal run of consecutive high cycles
cfg_msb  in  1  1 = first bit of burst is word MSB; 0 = first bit is LSB
word_data  out  32  reassembled word, right-justified, upper bits zero
word_len  out  2  length code 0=8, 1=16, 2=24, 3=32 bits
word_err  out  1  burst length was not 8/16/24/32
word_valid  out  1  FIFO head valid
word_ready  in  1  consumer accepts head
overflow  out  1  sticky: a completed word was dropped because the FIFO was full
busy  out  1  burst in progress (state RECV)

Behaviour:
- Reset values: reset is synchronous, active-high; clock is clk. All outputs are 0. FIFO is empty, state is IDLE, count=0, shift register=0, overflow=0.
- FSM states:
  - IDLE: when so_valid=1, go to RECV. Capture the first bit and latch cfg_msb into msb_q. count<=1.
  - RECV: while so_valid=1, capture the next bit. count increments and saturates at 33.
  - RECV -> IDLE when so_valid=0. On that same edge the completed entry is pushed and count is cleared.
- Bit capture, MSB-first: sh <= {sh[30:0], so_data}.
- Bit capture, LSB-first: sh[count] <= so_data.
- Bits beyond 32 are discarded, so sh holds the first 32 bits.
- The captured value is right-justified in both bit orders. Example: an 8-bit burst yields 0x000000XX.
- The shift register clears at the start of each burst.
- cfg_msb changes mid-burst are ignored; msb_q governs the whole burst.
- Length decode at push:
  - count in {8,16,24,32}: word_len=count/8-1, word_err=0.
  - Otherwise: word_len=0, word_err=1. The data is still pushed, holding the captured bits.
- FIFO entry is {err, len[1:0], data[31:0]} = 35 bits.
- Latency: the last bit is sampled at edge t and the push happens at edge t+1. On an empty FIFO, word_valid is high after edge t+1.
- Minimum inter-burst gap is 1 idle cycle. A new burst starting the cycle after the push is captured correctly.
- Handshake:
  - word_valid = FIFO not empty.
  - A pop occurs on an edge with word_valid & word_ready.
  - Head outputs hold stable while word_valid=1 and word_ready=0.
  - When empty, word_data/len/err read 0.
- Full FIFO:
  - A push with no pop drops the entry and sets overflow (sticky until reset).
  - A push and pop on the same edge while full: both occur, nothing is dropped, occupancy stays at FIFO_DEPTH.
- Empty FIFO: word_ready is ignored and pointers do not move.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Reset mid-burst: the partial word is discarded, nothing is pushed, and capture resumes at the next so_valid rising edge after reset deasserts.
- A burst of length 1 is legal input; it is pushed with word_err=1.

Decomposition:
- Package sti_pkg holds:
  - length codes LEN8/LEN16/LEN24/LEN32 (0..3)
  - FSM state encoding IDLE/RECV
  - ENTRY_W = 35
  - count width 6
- One sub-module: sti_word_fifo, a synchronous FIFO parameterised by width and depth, with push/pop/full/empty ports. The same stage will reuse it for pixel-stream buffering.
- FSM, shift register and length decode stay in the top module.

Test Plan:
- MSB-first 8-bit burst: cfg_msb=1, bits 1,0,1,0,0,1,0,1, word_ready=1 -> one word 0x000000A5, len=0, err=0; word_valid rises 1 cycle after the last bit.
- LSB-first 16-bit burst: cfg_msb=0, value 0x1234 sent LSB first -> word_data=0x00001234, len=1; cfg_msb toggled mid-burst has no effect.
- Back-to-back 32-bit bursts 0xDEADBEEF and 0x0F0F0F0F, 1-cycle gap, MSB-first -> two words in order, len=3, busy low only during the gap.
- 12-bit burst and 40-bit burst -> err=1, len=0; 40-bit word_data holds the first 32 bits.
- word_ready=0, five 8-bit bursts with FIFO_DEPTH=4 -> four words held, fifth dropped, overflow=1. Then word_ready=1 drains the four in order; a sixth burst whose push coincides with a pop at full is accepted.
- reset asserted after 5 bits of a 16-bit burst -> no word pushed, all outputs 0. The next full 8-bit burst 0x3C is captured correctly.
